sdff_scan_bank: RTL and testbench



---
 rtl/sdff_scan_pkg.sv | 33 +++
 rtl/sdff_scan_chain.sv | 40 ++++
 rtl/sdff_scan_bank.sv | 73 +++++++
 tb/tb_sdff_scan_bank.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdff_scan_pkg.sv
// Shared definitions for the mux-scan register bank: geometry helpers and the
// per-edge mode encoding used by the RTL and by its bench.
package sdff_scan_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_RESET   = 2'd0;
    localparam mode_t MODE_SHIFT   = 2'd1;
    localparam mode_t MODE_CAPTURE = 2'd2;
    localparam mode_t MODE_HOLD    = 2'd3;

    function automatic int chain_len(input int width, input int chains);
        return width / chains;
    endfunction

    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

    // Reset beats shift, shift beats capture, capture beats hold.
    function automatic mode_t decode_mode(input logic rn, input logic se, input logic e);
        if (!rn) begin
            return MODE_RESET;
        end else if (se) begin
            return MODE_SHIFT;
        end else if (e) begin
            return MODE_CAPTURE;
        end else begin
            return MODE_HOLD;
        end
    endfunction

endpackage

// File: rtl/sdff_scan_chain.sv
// One L-bit mux-scan chain: shifts toward bit 0 with SI entering at the top,
// captures D when enabled, and presents bit 0 as scan-out.
module sdff_scan_chain #(
    parameter int L = 4
) (
    input  logic         CLK,
    input  logic         RN,
    input  logic         SE,
    input  logic         E,
    input  logic [L-1:0] D,
    input  logic         SI,
    input  logic [L-1:0] RESET_VAL,
    output logic [L-1:0] Q,
    output logic         SO
);

    logic [L-1:0] shifted;

    generate
        if (L == 1) begin : g_single
            assign shifted = SI;
        end else begin : g_multi
            assign shifted = {SI, Q[L-1:1]};
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RN) begin
            Q <= RESET_VAL;
        end else if (SE) begin
            Q <= shifted;
        end else if (E) begin
            Q <= D;
        end
    end

    // Unload bit is visible before the first shift edge; no lockup latch.
    assign SO = Q[0];

endmodule

// File: rtl/sdff_scan_bank.sv
// WIDTH-bit mux-scan register bank split into CHAINS equal chains, with a shared
// shift-run counter that flags when a full chain length has been shifted.
module sdff_scan_bank
    import sdff_scan_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CHAINS    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              SE,
    input  logic              E,
    input  logic [WIDTH-1:0]  D,
    input  logic [CHAINS-1:0] SI,
    output logic [WIDTH-1:0]  Q,
    output logic [CHAINS-1:0] SO,
    output logic              SHIFT_DONE
);

    localparam int L  = chain_len(WIDTH, CHAINS);
    localparam int CW = cnt_width(L);
    localparam logic [CW-1:0] L_CNT = CW'(L);

    generate
        if (CHAINS < 1 || CHAINS > WIDTH || (WIDTH % CHAINS) != 0) begin : g_bad_geometry
            $error("sdff_scan_bank: WIDTH must split into CHAINS equal chains");
        end
    endgenerate

    genvar c;
    generate
        for (c = 0; c < CHAINS; c++) begin : g_chain
            sdff_scan_chain #(.L(L)) u_chain (
                .CLK       (CLK),
                .RN        (RN),
                .SE        (SE),
                .E         (E),
                .D         (D[c*L +: L]),
                .SI        (SI[c]),
                .RESET_VAL (RESET_VAL[c*L +: L]),
                .Q         (Q[c*L +: L]),
                .SO        (SO[c])
            );
        end
    endgenerate

    mode_t         mode;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    assign mode = decode_mode(RN, SE, E);

    // Counts consecutive shift edges, saturating at L; any non-shift edge clears it.
    always_comb begin
        cnt_next = '0;
        case (mode)
            MODE_SHIFT: cnt_next = (cnt == L_CNT) ? cnt : cnt + CW'(1);
            default:    cnt_next = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            cnt        <= '0;
            SHIFT_DONE <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            SHIFT_DONE <= (cnt_next == L_CNT);
        end
    end

endmodule

// File: tb/tb_sdff_scan_bank.sv
// Bench for sdff_scan_bank: directed scenarios with literal expectations plus
// randomized traffic, all checked against a queue-per-chain reference model.
module tb_sdff_scan_bank;
    import sdff_scan_pkg::*;

    localparam int WIDTH  = 8;
    localparam int CHAINS = 2;
    localparam int L      = WIDTH / CHAINS;
    localparam logic [WIDTH-1:0] RST_VAL = 8'h00;
    localparam int EW = WIDTH + CHAINS + 1;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rn  = 1'b1;
    logic              se  = 1'b0;
    logic              e   = 1'b0;
    logic [WIDTH-1:0]  d   = '0;
    logic [CHAINS-1:0] si  = '0;
    logic [WIDTH-1:0]  q;
    logic [CHAINS-1:0] so;
    logic              shift_done;

    always #5 clk = ~clk;

    sdff_scan_bank #(
        .WIDTH     (WIDTH),
        .CHAINS    (CHAINS),
        .RESET_VAL (RST_VAL)
    ) dut (
        .CLK        (clk),
        .RN         (rn),
        .SE         (se),
        .E          (e),
        .D          (d),
        .SI         (si),
        .Q          (q),
        .SO         (so),
        .SHIFT_DONE (shift_done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each chain is a queue whose front is the bit nearest SO.
    bit   ch_q [CHAINS][$];
    int   run_len   = 0;
    bit   mdl_valid = 1'b0;
    logic [EW-1:0] exp_q[$];

    function automatic logic [WIDTH-1:0] mdl_q();
        logic [WIDTH-1:0] v;
        v = '0;
        for (int c = 0; c < CHAINS; c++)
            for (int i = 0; i < L; i++)
                v[c*L + i] = ch_q[c][i];
        return v;
    endfunction

    function automatic logic [CHAINS-1:0] mdl_so();
        logic [CHAINS-1:0] v;
        for (int c = 0; c < CHAINS; c++) v[c] = ch_q[c][0];
        return v;
    endfunction

    function automatic logic mdl_done();
        return run_len >= L;
    endfunction

    initial begin
        for (int c = 0; c < CHAINS; c++)
            for (int i = 0; i < L; i++) ch_q[c].push_back(1'b0);
    end

    always @(posedge clk) begin
        mode_t m;
        if (!rn)     m = MODE_RESET;
        else if (se) m = MODE_SHIFT;
        else if (e)  m = MODE_CAPTURE;
        else         m = MODE_HOLD;
        case (m)
            MODE_RESET: begin
                for (int c = 0; c < CHAINS; c++) begin
                    ch_q[c].delete();
                    for (int i = 0; i < L; i++) ch_q[c].push_back(RST_VAL[c*L + i]);
                end
                run_len   = 0;
                mdl_valid = 1'b1;
            end
            MODE_SHIFT: begin
                for (int c = 0; c < CHAINS; c++) begin
                    void'(ch_q[c].pop_front());
                    ch_q[c].push_back(si[c]);
                end
                if (run_len < L) run_len++;
            end
            MODE_CAPTURE: begin
                for (int c = 0; c < CHAINS; c++)
                    for (int i = 0; i < L; i++) ch_q[c][i] = d[c*L + i];
                run_len   = 0;
                mdl_valid = 1'b1;
            end
            default: run_len = 0;
        endcase
        if (mdl_valid) exp_q.push_back({mdl_q(), mdl_so(), mdl_done()});
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [EW-1:0] x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("sb_q",    32'(q),          32'(x[EW-1 -: WIDTH]));
            chk("sb_so",   32'(so),         32'(x[CHAINS:1]));
            chk("sb_done", 32'(shift_done), 32'(x[0]));
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic t_rn, input logic t_se, input logic t_e,
                        input logic [WIDTH-1:0] t_d, input logic [CHAINS-1:0] t_si);
        @(negedge clk);
        #1;
        rn = t_rn;
        se = t_se;
        e  = t_e;
        d  = t_d;
        si = t_si;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [WIDTH-1:0] q_before;
        logic [CHAINS-1:0] so0_seq, so1_seq;
        so0_seq = 4'b0101;  // bit k = SO[0] before edge k+1 (1,0,1,0)
        so1_seq = 4'b1010;  // (0,1,0,1)
        so0_seq = so0_seq;  // keep widths explicit below

        // Preload Q=3C, then reset with SE=E=1 asserted.
        step(1'b1, 1'b0, 1'b1, 8'h3C, 2'b00);
        chk("preload_q", 32'(q), 32'h3C);
        step(1'b0, 1'b1, 1'b1, 8'hFF, 2'b11);
        chk("reset_q", 32'(q), 32'h00);
        chk("reset_so", 32'(so), 32'h0);
        chk("reset_done", 32'(shift_done), 32'h0);
        chk("model_reset_q", 32'(mdl_q()), 32'h00);

        // Capture then hold.
        step(1'b1, 1'b0, 1'b1, 8'hA5, 2'b00);
        chk("capture_q", 32'(q), 32'hA5);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'hFF, 2'b00);
            chk("hold_q", 32'(q), 32'hA5);
        end
        chk("model_hold_q", 32'(mdl_q()), 32'hA5);

        // Unload A5 while loading SI=10 into both chains.
        begin
            logic [3:0] s0, s1;
            s0 = 4'b0101;
            s1 = 4'b1010;
            for (int k = 0; k < 4; k++) begin
                chk("unload_so0", 32'(so[0]), 32'(s0[k]));
                chk("unload_so1", 32'(so[1]), 32'(s1[k]));
                step(1'b1, 1'b1, 1'b0, 8'h00, 2'b10);
                chk("unload_done", 32'(shift_done), (k == 3) ? 32'h1 : 32'h0);
            end
        end
        chk("unload_q", 32'(q), 32'hF0);
        chk("model_unload_q", 32'(mdl_q()), 32'hF0);

        // Shift wins over capture.
        step(1'b1, 1'b0, 1'b1, 8'hA5, 2'b00);
        step(1'b1, 1'b1, 1'b1, 8'hFF, 2'b00);
        chk("prio_q", 32'(q), 32'h52);
        chk("prio_done", 32'(shift_done), 32'h0);
        chk("model_prio_q", 32'(mdl_q()), 32'h52);

        // Reset mid-shift restarts the count.
        step(1'b1, 1'b1, 1'b0, 8'h00, 2'b11);
        step(1'b0, 1'b1, 1'b0, 8'h00, 2'b11);
        chk("midrst_q", 32'(q), 32'h00);
        chk("midrst_done", 32'(shift_done), 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00, 2'($urandom_range(0, 3)));
            chk("midrst_run_done", 32'(shift_done), (k == 3) ? 32'h1 : 32'h0);
        end

        // Saturation past L, then a hold edge clears the flag.
        step(1'b1, 1'b0, 1'b0, 8'h00, 2'b00);
        chk("clear_done", 32'(shift_done), 32'h0);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00, 2'($urandom_range(0, 3)));
            chk("sat_done", 32'(shift_done), (k >= 3) ? 32'h1 : 32'h0);
        end
        q_before = mdl_q();
        step(1'b1, 1'b0, 1'b0, 8'h3C, 2'b11);
        chk("sat_clear_done", 32'(shift_done), 32'h0);
        chk("sat_hold_q", 32'(q), 32'(q_before));

        // Randomized traffic; SE biased high so full-length runs occur.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 8'($urandom),
                 2'($urandom_range(0, 3)));
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
